// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/stall controller: FSM encoding,
// widths, pipeline-control patterns and a saturating-increment helper.
package pipe_ctrl_pkg;

  localparam int REG_W_DEF = 5;
  localparam int CNT_W     = 16;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } pipe_state_e;

  // Bit order: {pc_freeze, ifid_freeze, ifid_flush, idex_freeze, idex_flush, exmem_freeze, memwb_flush}
  localparam logic [6:0] CTRL_NONE   = 7'b0000000;
  localparam logic [6:0] CTRL_BUBBLE = 7'b1100100;
  localparam logic [6:0] CTRL_FLUSH  = 7'b0010100;
  localparam logic [6:0] CTRL_HOLD   = 7'b1101011;

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Bundle of pipeline-stage status inputs and pipeline-register control outputs
// exchanged between the pipeline datapath (master) and pipe_ctrl (slave).
interface pipe_ctrl_if
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W = REG_W_DEF
);

  logic [REG_W-1:0] id_src1;
  logic [REG_W-1:0] id_src2;
  logic             id_two_src;
  logic [REG_W-1:0] exe_dest;
  logic             exe_wb_en;
  logic             exe_mem_r_en;
  logic [REG_W-1:0] mem_dest;
  logic             mem_wb_en;
  logic             fwd_en;
  logic             br_taken;
  logic             mem_req;
  logic             mem_ready;

  logic             pc_freeze;
  logic             ifid_freeze;
  logic             ifid_flush;
  logic             idex_freeze;
  logic             idex_flush;
  logic             exmem_freeze;
  logic             memwb_flush;
  logic             mem_err;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic [CNT_W-1:0] wait_cnt_tot;

  modport master (
    output id_src1, id_src2, id_two_src, exe_dest, exe_wb_en, exe_mem_r_en,
           mem_dest, mem_wb_en, fwd_en, br_taken, mem_req, mem_ready,
    input  pc_freeze, ifid_freeze, ifid_flush, idex_freeze, idex_flush,
           exmem_freeze, memwb_flush, mem_err, state, stall_cnt, flush_cnt, wait_cnt_tot
  );

  modport slave (
    input  id_src1, id_src2, id_two_src, exe_dest, exe_wb_en, exe_mem_r_en,
           mem_dest, mem_wb_en, fwd_en, br_taken, mem_req, mem_ready,
    output pc_freeze, ifid_freeze, ifid_flush, idex_freeze, idex_flush,
           exmem_freeze, memwb_flush, mem_err, state, stall_cnt, flush_cnt, wait_cnt_tot
  );

endinterface

// File: rtl/pipe_hazard_detect.sv
// Combinational register-match logic: flags a data hazard between the ID-stage
// sources and the EXE/MEM destinations, honouring forwarding and register 0.
module pipe_hazard_detect
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W = REG_W_DEF
) (
  input  logic [REG_W-1:0] id_src1_i,
  input  logic [REG_W-1:0] id_src2_i,
  input  logic             id_two_src_i,
  input  logic [REG_W-1:0] exe_dest_i,
  input  logic             exe_wb_en_i,
  input  logic             exe_mem_r_en_i,
  input  logic [REG_W-1:0] mem_dest_i,
  input  logic             mem_wb_en_i,
  input  logic             fwd_en_i,
  output logic             hazard_o
);

  logic exeMatch;
  logic memMatch;

  // With forwarding only a load in EXE cannot be bypassed in time.
  always_comb begin
    exeMatch = (exe_dest_i != '0) &&
               ((exe_dest_i == id_src1_i) || (id_two_src_i && (exe_dest_i == id_src2_i)));
    memMatch = (mem_dest_i != '0) &&
               ((mem_dest_i == id_src1_i) || (id_two_src_i && (mem_dest_i == id_src2_i)));
    if (fwd_en_i) begin
      hazard_o = exe_mem_r_en_i && exeMatch;
    end else begin
      hazard_o = (exe_wb_en_i && exeMatch) || (mem_wb_en_i && memMatch);
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: memory-wait FSM with watchdog, prioritised freeze/flush
// generation and optional performance counters (enabled by PIPE_CTRL_PERF_EN).
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W       = REG_W_DEF,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  pipe_ctrl_if.slave bus
);

  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [WAIT_W-1:0] TIMEOUT_CNT = WAIT_W'(MEM_TIMEOUT);

  pipe_state_e       state_q, state_d;
  logic              memErr_q, memErr_d;
  logic [WAIT_W-1:0] waitCnt_q, waitCnt_d;
  logic              hazard;
  logic              memStall;
  logic [6:0]        ctrl;
  logic              stallEv, flushEv, waitEv;

  pipe_hazard_detect #(.REG_W(REG_W)) uHazard (
    .id_src1_i     (bus.id_src1),
    .id_src2_i     (bus.id_src2),
    .id_two_src_i  (bus.id_two_src),
    .exe_dest_i    (bus.exe_dest),
    .exe_wb_en_i   (bus.exe_wb_en),
    .exe_mem_r_en_i(bus.exe_mem_r_en),
    .mem_dest_i    (bus.mem_dest),
    .mem_wb_en_i   (bus.mem_wb_en),
    .fwd_en_i      (bus.fwd_en),
    .hazard_o      (hazard)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RUN;
      memErr_q  <= 1'b0;
      waitCnt_q <= '0;
    end else begin
      state_q   <= state_d;
      memErr_q  <= memErr_d;
      waitCnt_q <= waitCnt_d;
    end
  end

  // The wait counter holds the number of cycles the access has been outstanding.
  always_comb begin
    state_d   = state_q;
    memErr_d  = memErr_q;
    waitCnt_d = waitCnt_q;
    case (state_q)
      RUN: begin
        if (bus.mem_req && !bus.mem_ready) begin
          state_d   = MEM_WAIT;
          waitCnt_d = WAIT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (bus.mem_ready) begin
          state_d   = RUN;
          waitCnt_d = '0;
        end else if ((MEM_TIMEOUT != 0) && (waitCnt_q == TIMEOUT_CNT)) begin
          state_d  = HALT;
          memErr_d = 1'b1;
        end else begin
          waitCnt_d = waitCnt_q + 1'b1;
        end
      end
      HALT:    state_d = HALT;
      default: state_d = RUN;
    endcase
  end

  // A branch that coincides with a memory stall is dropped here; the frozen
  // ID/EX register presents it again once the stall clears.
  always_comb begin
    ctrl     = CTRL_NONE;
    stallEv  = 1'b0;
    flushEv  = 1'b0;
    waitEv   = 1'b0;
    memStall = bus.mem_req && !bus.mem_ready && (state_q != HALT);
    if (!rst) begin
      if (state_q == HALT) begin
        ctrl = CTRL_HOLD;
      end else if (memStall) begin
        ctrl   = CTRL_HOLD;
        waitEv = 1'b1;
      end else if (bus.br_taken) begin
        ctrl    = CTRL_FLUSH;
        flushEv = 1'b1;
      end else if (hazard) begin
        ctrl    = CTRL_BUBBLE;
        stallEv = 1'b1;
      end
    end
  end

  assign {bus.pc_freeze, bus.ifid_freeze, bus.ifid_flush, bus.idex_freeze,
          bus.idex_flush, bus.exmem_freeze, bus.memwb_flush} = ctrl;
  assign bus.mem_err = memErr_q;
  assign bus.state   = state_q;

`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] stallCnt_q, flushCnt_q, waitTot_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stallCnt_q <= '0;
      flushCnt_q <= '0;
      waitTot_q  <= '0;
    end else begin
      if (stallEv) stallCnt_q <= satInc(stallCnt_q);
      if (flushEv) flushCnt_q <= satInc(flushCnt_q);
      if (waitEv)  waitTot_q  <= satInc(waitTot_q);
    end
  end

  assign bus.stall_cnt    = stallCnt_q;
  assign bus.flush_cnt    = flushCnt_q;
  assign bus.wait_cnt_tot = waitTot_q;
`else
  logic unusedEvents;
  assign unusedEvents     = ^{stallEv, flushEv, waitEv};
  assign bus.stall_cnt    = '0;
  assign bus.flush_cnt    = '0;
  assign bus.wait_cnt_tot = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: dutA uses the default watchdog, dutB uses
// MEM_TIMEOUT=3 to reach HALT; counter expectations follow PIPE_CTRL_PERF_EN.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

`ifdef PIPE_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  typedef enum int {K_NONE, K_BUBBLE, K_BRANCH, K_MSTALL, K_HALT} kindE;

  typedef struct packed {
    logic [4:0] src1;
    logic [4:0] src2;
    logic       twoSrc;
    logic [4:0] exeDest;
    logic       exeWb;
    logic       exeMemR;
    logic [4:0] memDest;
    logic       memWb;
    logic       fwd;
    logic       br;
    logic       memReq;
    logic       memReady;
  } stimT;

  typedef struct {
    bit         sel;
    logic [6:0] ctrl;
    logic [1:0] st;
    logic       err;
    string      tag;
  } expT;

  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic rst2 = 1'b1;

  pipe_ctrl_if #(.REG_W(5)) busA ();
  pipe_ctrl_if #(.REG_W(5)) busB ();

  pipe_ctrl #(.REG_W(5), .MEM_TIMEOUT(255)) dutA (.clk(clk), .rst(rst),  .bus(busA));
  pipe_ctrl #(.REG_W(5), .MEM_TIMEOUT(3))   dutB (.clk(clk), .rst(rst2), .bus(busB));

  int          checkCount = 0;
  int          errCount   = 0;
  expT         sbQ[$];
  expT         sbHead;
  logic [6:0]  actCtrl;
  logic [1:0]  actSt;
  logic        actErr;
  logic [15:0] expStall = '0;
  logic [15:0] expFlush = '0;
  logic [15:0] expWait  = '0;

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  function automatic logic [6:0] kindCtrl(input kindE k);
    case (k)
      K_BUBBLE:        return 7'b1100100;
      K_BRANCH:        return 7'b0010100;
      K_MSTALL, K_HALT: return 7'b1101011;
      default:         return 7'b0000000;
    endcase
  endfunction

  function automatic logic [15:0] satAdd(input logic [15:0] v, input int n);
    int s;
    s = int'(v) + n;
    return (s > 65535) ? 16'hFFFF : 16'(s);
  endfunction

  task automatic driveBus(input bit sel, input stimT s);
    if (!sel) begin
      busA.id_src1 = s.src1;     busA.id_src2 = s.src2;       busA.id_two_src = s.twoSrc;
      busA.exe_dest = s.exeDest; busA.exe_wb_en = s.exeWb;    busA.exe_mem_r_en = s.exeMemR;
      busA.mem_dest = s.memDest; busA.mem_wb_en = s.memWb;    busA.fwd_en = s.fwd;
      busA.br_taken = s.br;      busA.mem_req = s.memReq;     busA.mem_ready = s.memReady;
    end else begin
      busB.id_src1 = s.src1;     busB.id_src2 = s.src2;       busB.id_two_src = s.twoSrc;
      busB.exe_dest = s.exeDest; busB.exe_wb_en = s.exeWb;    busB.exe_mem_r_en = s.exeMemR;
      busB.mem_dest = s.memDest; busB.mem_wb_en = s.memWb;    busB.fwd_en = s.fwd;
      busB.br_taken = s.br;      busB.mem_req = s.memReq;     busB.mem_ready = s.memReady;
    end
  endtask

  // Drives one cycle of stimulus on the selected DUT and queues what it must show.
  task automatic applyStimulus(input bit sel, input stimT s, input bit r, input kindE k,
                               input logic [1:0] st, input logic err, input string tag);
    expT e;
    driveBus(sel, s);
    driveBus(!sel, '0);
    if (sel) rst2 = r;
    else     rst  = r;
    e.sel  = sel;
    e.ctrl = kindCtrl(k);
    e.st   = st;
    e.err  = err;
    e.tag  = tag;
    sbQ.push_back(e);
    if (!sel && PERF) begin
      if (r) begin
        expStall = '0;
        expFlush = '0;
        expWait  = '0;
      end else begin
        case (k)
          K_BUBBLE: expStall = satAdd(expStall, 1);
          K_BRANCH: expFlush = satAdd(expFlush, 1);
          K_MSTALL: expWait  = satAdd(expWait, 1);
          default:  ;
        endcase
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic checkCounters(input string tag);
    checkOutput({tag, ".stall_cnt"},    busA.stall_cnt,    expStall);
    checkOutput({tag, ".flush_cnt"},    busA.flush_cnt,    expFlush);
    checkOutput({tag, ".wait_cnt_tot"}, busA.wait_cnt_tot, expWait);
  endtask

  always @(negedge clk) begin
    if (sbQ.size() != 0) begin
      sbHead = sbQ.pop_front();
      if (!sbHead.sel) begin
        actCtrl = {busA.pc_freeze, busA.ifid_freeze, busA.ifid_flush, busA.idex_freeze,
                   busA.idex_flush, busA.exmem_freeze, busA.memwb_flush};
        actSt   = busA.state;
        actErr  = busA.mem_err;
      end else begin
        actCtrl = {busB.pc_freeze, busB.ifid_freeze, busB.ifid_flush, busB.idex_freeze,
                   busB.idex_flush, busB.exmem_freeze, busB.memwb_flush};
        actSt   = busB.state;
        actErr  = busB.mem_err;
      end
      checkOutput({sbHead.tag, ".ctrl"},    16'(actCtrl), 16'(sbHead.ctrl));
      checkOutput({sbHead.tag, ".state"},   16'(actSt),   16'(sbHead.st));
      checkOutput({sbHead.tag, ".mem_err"}, 16'(actErr),  16'(sbHead.err));
    end
  end

  initial begin
    stimT s;
    driveBus(1'b0, '0);
    driveBus(1'b1, '0);
    @(posedge clk);
    #1;

    applyStimulus(0, '0, 1, K_NONE, RUN, 0, "resetA");
    applyStimulus(0, '0, 0, K_NONE, RUN, 0, "idleA");

    s = '0; s.fwd = 1; s.exeMemR = 1; s.exeWb = 1; s.exeDest = 5'd3; s.src1 = 5'd3;
    applyStimulus(0, s, 0, K_BUBBLE, RUN, 0, "loadUse");
    s.exeDest = 5'd0; s.src1 = 5'd0;
    applyStimulus(0, s, 0, K_NONE, RUN, 0, "loadUseR0");
    s = '0; s.fwd = 1; s.exeWb = 1; s.exeDest = 5'd3; s.src1 = 5'd3;
    applyStimulus(0, s, 0, K_NONE, RUN, 0, "fwdAlu");

    s = '0; s.memWb = 1; s.memDest = 5'd7; s.twoSrc = 1; s.src1 = 5'd1; s.src2 = 5'd7;
    applyStimulus(0, s, 0, K_BUBBLE, RUN, 0, "memSrc2");
    s.twoSrc = 0;
    applyStimulus(0, s, 0, K_NONE, RUN, 0, "memSrc2Off");
    s = '0; s.exeWb = 1; s.exeDest = 5'd4; s.src1 = 5'd4;
    applyStimulus(0, s, 0, K_BUBBLE, RUN, 0, "exeSrc1");
    s = '0; s.memWb = 1; s.memDest = 5'd0; s.src1 = 5'd0;
    applyStimulus(0, s, 0, K_NONE, RUN, 0, "memR0");

    s = '0; s.fwd = 1; s.exeMemR = 1; s.exeWb = 1; s.exeDest = 5'd3; s.src1 = 5'd3; s.br = 1;
    applyStimulus(0, s, 0, K_BRANCH, RUN, 0, "brHaz");
    checkCounters("afterBranch");

    // Branch held by the frozen ID/EX while memory waits four cycles.
    s.memReq = 1; s.memReady = 0;
    applyStimulus(0, s, 0, K_MSTALL, RUN, 0, "memBr");
    for (int i = 0; i < 3; i++) applyStimulus(0, s, 0, K_MSTALL, MEM_WAIT, 0, "memWait");
    s.memReady = 1;
    applyStimulus(0, s, 0, K_BRANCH, MEM_WAIT, 0, "memDone");
    applyStimulus(0, '0, 0, K_NONE, RUN, 0, "memExit");
    checkCounters("afterMem");

    s = '0; s.memReq = 1;
    applyStimulus(0, s, 0, K_MSTALL, RUN, 0, "rstMwEnter");
    applyStimulus(0, s, 0, K_MSTALL, MEM_WAIT, 0, "rstMwWait");
    applyStimulus(0, s, 1, K_NONE, RUN, 0, "rstMidWait");
    checkCounters("afterReset");
    applyStimulus(0, '0, 0, K_NONE, RUN, 0, "rstRelease");

`ifdef PIPE_CTRL_PERF_EN
    s = '0; s.exeWb = 1; s.exeDest = 5'd9; s.src1 = 5'd9;
    applyStimulus(0, s, 0, K_BUBBLE, RUN, 0, "satStart");
    repeat (65536) @(posedge clk);
    #1;
    expStall = satAdd(expStall, 65536);
    checkCounters("satHold");
    applyStimulus(0, s, 0, K_BUBBLE, RUN, 0, "satMore");
    s = '0; s.br = 1;
    applyStimulus(0, s, 0, K_BRANCH, RUN, 0, "satBranch");
    checkCounters("satMore");
`else
    s = '0; s.exeWb = 1; s.exeDest = 5'd9; s.src1 = 5'd9;
    applyStimulus(0, s, 0, K_BUBBLE, RUN, 0, "noPerfStall");
    s = '0; s.br = 1;
    applyStimulus(0, s, 0, K_BRANCH, RUN, 0, "noPerfBranch");
    checkCounters("noPerf");
`endif
    applyStimulus(0, '0, 0, K_NONE, RUN, 0, "idleA2");

    applyStimulus(1, '0, 1, K_NONE, RUN, 0, "resetB");
    applyStimulus(1, '0, 0, K_NONE, RUN, 0, "idleB");
    s = '0; s.memReq = 1;
    applyStimulus(1, s, 0, K_MSTALL, RUN, 0, "wdEnter");
    for (int i = 0; i < 3; i++) applyStimulus(1, s, 0, K_MSTALL, MEM_WAIT, 0, "wdWait");
    applyStimulus(1, s, 0, K_HALT, HALT, 1, "wdHalt");
    applyStimulus(1, '0, 0, K_HALT, HALT, 1, "haltIdle");
    s = '0; s.br = 1; s.fwd = 1; s.exeMemR = 1; s.exeDest = 5'd3; s.src1 = 5'd3;
    applyStimulus(1, s, 0, K_HALT, HALT, 1, "haltBr");
    s = '0; s.memReq = 1; s.memReady = 1;
    applyStimulus(1, s, 0, K_HALT, HALT, 1, "haltReady");
    applyStimulus(1, '0, 1, K_NONE, RUN, 0, "haltReset");
    applyStimulus(1, '0, 0, K_NONE, RUN, 0, "haltRelease");

    @(negedge clk);
    #1;
    checkOutput("sbEmpty", 16'(sbQ.size()), 16'd0);
    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL provide parameter REG_W, default 5, register-address width.
REQ-002 SHALL provide parameter MEM_TIMEOUT, default 255, maximum MEM_WAIT cycles before halt; 0 disables the watchdog.
REQ-003 SHALL provide ports: clk  in  1  clock; rst  in  1  asynchronous active-high reset.
REQ-004 SHALL provide ports: id_src1, id_src2  in  REG_W  ID-stage source registers; id_two_src  in  1  ID instruction reads src2.
REQ-005 SHALL provide ports: exe_dest  in  REG_W; exe_wb_en  in  1; exe_mem_r_en  in  1  EXE-stage destination/write/load flags.
REQ-006 SHALL provide ports: mem_dest  in  REG_W; mem_wb_en  in  1  MEM-stage destination/write flags.
REQ-007 SHALL provide ports: fwd_en  in  1  forwarding enabled; br_taken  in  1  EXE branch taken; mem_req  in  1  MEM stage accessing memory; mem_ready  in  1  memory done.
REQ-008 SHALL provide ports: pc_freeze, ifid_freeze, ifid_flush, idex_freeze, idex_flush, exmem_freeze, memwb_flush  out  1  pipeline-register controls.
REQ-009 SHALL provide ports: mem_err  out  1  sticky watchdog error; state  out  2  FSM state; stall_cnt, flush_cnt, wait_cnt_tot  out  16  performance counters.

Function
REQ-010 SHALL define data hazard, with fwd_en=0, as (exe_wb_en and exe_dest!=0 and exe_dest matches src) or (mem_wb_en and mem_dest!=0 and mem_dest matches src).
REQ-011 SHALL define data hazard, with fwd_en=1, only as exe_mem_r_en and exe_dest!=0 and exe_dest matches src.
REQ-012 SHALL match src as id_src1, or id_src2 only when id_two_src=1.
REQ-013 SHALL implement FSM states RUN=0, MEM_WAIT=1, HALT=2.
REQ-014 SHALL transition RUN->MEM_WAIT when mem_req=1 and mem_ready=0, loading the wait counter with 1.
REQ-015 SHALL transition MEM_WAIT->RUN on mem_ready=1 and clear the wait counter.
REQ-016 SHALL transition MEM_WAIT->HALT, setting mem_err, when mem_ready=0 and the wait counter equals MEM_TIMEOUT (MEM_TIMEOUT!=0); otherwise it increments the wait counter.
REQ-017 SHALL leave HALT only on rst.
REQ-018 SHALL assert the memory stall combinationally as mem_req and not mem_ready in RUN or MEM_WAIT: pc_freeze, ifid_freeze, idex_freeze, exmem_freeze and memwb_flush =1, all others 0.
REQ-019 SHALL, for br_taken without a memory stall, assert ifid_flush=1 and idex_flush=1 with no freezes, in the same cycle.
REQ-020 SHALL, for a data hazard without a memory stall or branch, assert pc_freeze=1, ifid_freeze=1, idex_flush=1 (bubble).
REQ-021 SHALL apply priority HALT > memory stall > branch > data hazard; in HALT, all freezes and memwb_flush =1 and both other flushes =0.
REQ-022 SHALL drive all freeze/flush outputs to 0 when no condition applies.
REQ-023 SHALL, on simultaneous mem stall and br_taken, honour the stall only; the frozen ID/EX re-presents the branch later.

Reset
REQ-024 SHALL, on rst assertion, asynchronously set state=RUN, mem_err=0, the wait counter=0 and all performance counters=0.
REQ-025 SHALL force all freeze/flush outputs to 0 while rst=1, including reset asserted mid MEM_WAIT.

Configuration
REQ-026 SHALL, with PIPE_CTRL_PERF_EN defined, increment saturating 16-bit counters: stall_cnt per data-hazard stall cycle, flush_cnt per branch flush cycle, wait_cnt_tot per memory-stall cycle.
REQ-027 SHALL, without PIPE_CTRL_PERF_EN, keep the counter ports present, tied to 0, with no counter flops.

Structure
REQ-028 SHALL place the state encoding (RUN/MEM_WAIT/HALT) and the REG_W default in shared package pipe_ctrl_pkg.
REQ-029 SHALL implement the register-match logic in combinational sub-module pipe_hazard_detect, with the FSM, priority and counters in pipe_ctrl.

Verification
REQ-030 SHALL verify: fwd_en=1, exe_mem_r_en=1, exe_dest=3, id_src1=3 -> pc_freeze=1, ifid_freeze=1, idex_flush=1 for one cycle; exe_dest=0 -> no stall.
REQ-031 SHALL verify: fwd_en=0, mem_wb_en=1, mem_dest=7, id_two_src=1, id_src2=7 -> stall; same stimulus with id_two_src=0 -> no stall.
REQ-032 SHALL verify: br_taken=1 together with a data hazard -> ifid_flush=1, idex_flush=1, pc_freeze=0; flush_cnt +1.
REQ-033 SHALL verify: mem_req=1 with mem_ready low 4 cycles, then high -> state MEM_WAIT for 3 cycles, then RUN; exmem_freeze=1 for 4 cycles; wait_cnt_tot=4.
REQ-034 SHALL verify: MEM_TIMEOUT=3, mem_ready held 0 -> HALT after 3 MEM_WAIT cycles, mem_err=1 and all freezes=1 until rst, and rst then returns state=RUN with all outputs 0.
REQ-035 SHALL verify: stall_cnt at 65535 with further stalls -> stays 65535; without PIPE_CTRL_PERF_EN, all counters read 0.
